axis_rr_arb_mux: RTL and testbench
==================================

Name: axis_rr_arb_mux

Overview:
- Packet-level round-robin arbiter and multiplexer. It shares one AXI4-Stream output (one register stage) between S_COUNT AXI4-Stream sources.
- A grant is held for the whole packet, from the first beat through the beat with tlast, then rotates.
- It sits in front of the switch/register chain so that several producers can feed one stream consumer.

Parameters:
- S_COUNT, 4, number of input streams (2..16).
- DATA_WIDTH, 8, tdata width per stream.
- USER_WIDTH, 1, tuser width per stream.
- LAST_ENABLE, 1, 1 = hold the grant until the tlast beat; 0 = every beat is its own packet (arbitrate per beat).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  S_COUNT  per-port valid
- s_axis_tready  out  S_COUNT  per-port ready
- s_axis_tlast  in  S_COUNT  per-port last
- s_axis_tuser  in  S_COUNT*USER_WIDTH  per-port user
- m_axis_tdata  out  DATA_WIDTH  output data (registered)
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last (registered; forced to 1 when LAST_ENABLE=0)
- m_axis_tuser  out  USER_WIDTH  output user (registered)
- m_axis_tid  out  $clog2(S_COUNT)  index of the source port of the current output beat (present only with the optional feature)

Behaviour:
- Reset (synchronous): state=IDLE, grant_valid=0, grant=0, last_grant=S_COUNT-1 (port 0 has highest priority after reset), m_axis_tvalid=0, m_axis_tdata/tlast/tuser/tid=0, s_axis_tready=all 0.
- Reset mid-packet: the packet is abandoned and the output beat is dropped. There is no recovery of partial packets.
- State machine:
  - IDLE: if any s_axis_tvalid is set, pick the first asserted port scanning last_grant+1, last_grant+2, ... modulo S_COUNT. Register grant=that port, grant_valid=1, go to BUSY. No ready is asserted in IDLE.
  - BUSY: s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready). All other ready bits are 0.
  - Acceptance: a beat is accepted when s_axis_tvalid[grant] && s_axis_tready[grant]. It loads the output register on that edge and sets m_axis_tvalid=1.
  - Release (LAST_ENABLE=1): an accepted beat with tlast=1 sets last_grant=grant, grant_valid=0 and returns to IDLE on the same edge.
  - Release (LAST_ENABLE=0): every accepted beat releases the grant the same way.
- Output register:
  - If m_axis_tvalid && m_axis_tready and no new beat is accepted, m_axis_tvalid goes to 0 on the next edge.
  - Simultaneous output handshake and input acceptance: the register is overwritten and m_axis_tvalid stays 1 (full throughput inside a packet).
- Latency:
  - tvalid rising in IDLE (cycle N) -> grant at edge N+1 -> first beat accepted during cycle N+1 -> m_axis_tvalid=1 from cycle N+2.
  - One idle arbitration cycle is inserted between packets.
- A granted port whose tvalid drops mid-packet keeps the grant. The arbiter waits; there is no timeout.
- A requester that deasserts tvalid while in IDLE before being granted is simply skipped.
- Fairness: a port that has just finished a packet is considered last in the next scan. With every port requesting, grants rotate 0,1,2,...,S_COUNT-1,0.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, all s_axis_tready bits are 0 and the output holds stable.

Optional Feature:
- Macro: AXIS_RR_ARB_MUX_TID_EN.
- Defined: port m_axis_tid exists. It is registered together with tdata and equals the grant index of the beat held in the output register; reset value 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Single source: S_COUNT=4, port 2 sends 3 beats 0xA1,0xA2,0xA3 (tlast on 0xA3), m_axis_tready=1 -> m_axis_tvalid first high 2 cycles after tvalid; output 0xA1,0xA2,0xA3 on consecutive cycles; tlast only on 0xA3; m_axis_tid=2.
- All four ports request continuously, each with 2-beat packets -> output packet order port 0,1,2,3,0; no beat interleaving between packets; exactly one idle cycle between packets.
- Backpressure: m_axis_tready held 0 for 5 cycles while port 1 is mid-packet -> m_axis_tdata stable, all s_axis_tready=0, no beat lost or duplicated after tready returns to 1.
- Source stall: granted port 3 drops tvalid for 4 cycles mid-packet while port 0 requests -> port 0 stays ungranted until port 3's tlast beat is accepted.
- LAST_ENABLE=0: ports 0 and 1 each request 3 beats -> output alternates 0,1,0,1,0,1; m_axis_tlast=1 on every beat.
- Reset asserted mid-packet on port 1 -> next cycle m_axis_tvalid=0 and s_axis_tready=0. After release, with ports 0 and 1 both requesting, port 0 is granted first.

Source files
------------

// File: rtl/axis_rr_arb_mux.sv
// axis_rr_arb_mux
// Packet-level round-robin arbiter and multiplexer. S_COUNT AXI4-Stream
// sources share one registered AXI4-Stream output. A source keeps the grant
// from its first beat through its tlast beat (or for a single beat when
// LAST_ENABLE=0). The grant then rotates so that the source that just finished
// is scanned last.
//
// Optional feature: define AXIS_RR_ARB_MUX_TID_EN to add the m_axis_tid output.
// It carries the index of the source port of the beat held in the output
// register.
module axis_rr_arb_mux #(
    parameter int  S_COUNT     = 4,
    parameter int  DATA_WIDTH  = 8,
    parameter int  USER_WIDTH  = 1,
    parameter int  LAST_ENABLE = 1,
    localparam int ID_WIDTH    = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
`ifdef AXIS_RR_ARB_MUX_TID_EN
    output logic [ID_WIDTH-1:0]           m_axis_tid,
`endif
    output logic [USER_WIDTH-1:0]         m_axis_tuser
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [ID_WIDTH-1:0]   grant_reg, grant_next;
    logic [ID_WIDTH-1:0]   last_grant_reg, last_grant_next;
    logic                  grant_valid_reg, grant_valid_next;

    logic [DATA_WIDTH-1:0] m_tdata_reg, m_tdata_next;
    logic                  m_tvalid_reg, m_tvalid_next;
    logic                  m_tlast_reg, m_tlast_next;
    logic [USER_WIDTH-1:0] m_tuser_reg, m_tuser_next;
`ifdef AXIS_RR_ARB_MUX_TID_EN
    logic [ID_WIDTH-1:0]   m_tid_reg, m_tid_next;
`endif

    // Per-port views of the flattened input buses
    logic [DATA_WIDTH-1:0] s_data_arr [S_COUNT];
    logic [USER_WIDTH-1:0] s_user_arr [S_COUNT];

    // Selected (granted) source
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;

    // The output register can take a beat when empty or draining this cycle
    logic                  out_ready;
    logic                  accept;
    logic                  release_beat;

    // Round-robin search
    logic [2*S_COUNT-1:0]  req_dbl;
    logic [2*S_COUNT-1:0]  req_shift;
    logic [S_COUNT-1:0]    req_rot;
    logic [ID_WIDTH:0]     start_idx;
    logic                  arb_found;
    logic [ID_WIDTH-1:0]   arb_port;

    assign out_ready = !m_tvalid_reg || m_axis_tready;

    genvar gi;
    generate
        for (gi = 0; gi < S_COUNT; gi++) begin : g_port
            assign s_data_arr[gi]    = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_user_arr[gi]    = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
            // Only the granted port sees ready, and only while the grant is live
            assign s_axis_tready[gi] = grant_valid_reg && (grant_reg == ID_WIDTH'(gi)) && out_ready;
        end
    endgenerate

    assign sel_valid    = s_axis_tvalid[grant_reg];
    assign sel_last     = s_axis_tlast[grant_reg];
    assign sel_data     = s_data_arr[grant_reg];
    assign sel_user     = s_user_arr[grant_reg];

    assign accept       = grant_valid_reg && sel_valid && out_ready;
    assign release_beat = (LAST_ENABLE == 0) || sel_last;

    // Rotate the request vector so bit 0 is the port just after last_grant;
    // the duplicated vector makes the wrap-around a plain shift.
    assign req_dbl   = {s_axis_tvalid, s_axis_tvalid};
    assign start_idx = {1'b0, last_grant_reg} + (ID_WIDTH+1)'(1);
    assign req_shift = req_dbl >> start_idx;
    assign req_rot   = req_shift[S_COUNT-1:0];

    // Pick the first requesting port after last_grant, wrapping modulo S_COUNT
    always_comb begin
        logic [ID_WIDTH:0] sum;
        arb_found = 1'b0;
        arb_port  = '0;
        sum       = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (!arb_found && req_rot[k]) begin
                arb_found = 1'b1;
                sum = start_idx + (ID_WIDTH+1)'(k);
                if (sum >= (ID_WIDTH+1)'(S_COUNT)) begin
                    sum = sum - (ID_WIDTH+1)'(S_COUNT);
                end
                if (sum >= (ID_WIDTH+1)'(S_COUNT)) begin
                    sum = sum - (ID_WIDTH+1)'(S_COUNT);
                end
                arb_port = sum[ID_WIDTH-1:0];
            end
        end
    end

    // Next-state logic: grant in IDLE, move beats and release in BUSY
    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        grant_valid_next = grant_valid_reg;
        last_grant_next  = last_grant_reg;
        m_tvalid_next    = m_tvalid_reg && !m_axis_tready;
        m_tdata_next     = m_tdata_reg;
        m_tlast_next     = m_tlast_reg;
        m_tuser_next     = m_tuser_reg;
`ifdef AXIS_RR_ARB_MUX_TID_EN
        m_tid_next       = m_tid_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_next       = arb_port;
                    grant_valid_next = 1'b1;
                    state_next       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    // A new beat overwrites the register even while it drains
                    m_tvalid_next = 1'b1;
                    m_tdata_next  = sel_data;
                    m_tuser_next  = sel_user;
                    m_tlast_next  = (LAST_ENABLE == 0) ? 1'b1 : sel_last;
`ifdef AXIS_RR_ARB_MUX_TID_EN
                    m_tid_next    = grant_reg;
`else
                    // No source index is carried with the beat.
`endif
                    if (release_beat) begin
                        last_grant_next  = grant_reg;
                        grant_valid_next = 1'b0;
                        state_next       = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_valid_next = 1'b0;
                state_next       = ST_IDLE;
            end
        endcase
    end

    // State and output register; reset drops any partial packet
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            last_grant_reg  <= ID_WIDTH'(S_COUNT - 1);
            m_tvalid_reg    <= 1'b0;
            m_tdata_reg     <= '0;
            m_tlast_reg     <= 1'b0;
            m_tuser_reg     <= '0;
`ifdef AXIS_RR_ARB_MUX_TID_EN
            m_tid_reg       <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            grant_valid_reg <= grant_valid_next;
            last_grant_reg  <= last_grant_next;
            m_tvalid_reg    <= m_tvalid_next;
            m_tdata_reg     <= m_tdata_next;
            m_tlast_reg     <= m_tlast_next;
            m_tuser_reg     <= m_tuser_next;
`ifdef AXIS_RR_ARB_MUX_TID_EN
            m_tid_reg       <= m_tid_next;
`endif
        end
    end

    assign m_axis_tdata  = m_tdata_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tlast  = m_tlast_reg;
    assign m_axis_tuser  = m_tuser_reg;
`ifdef AXIS_RR_ARB_MUX_TID_EN
    assign m_axis_tid    = m_tid_reg;
`endif

endmodule

// File: tb/tb_axis_rr_arb_mux.sv
// tb_axis_rr_arb_mux
// Table-driven check of single-source latency and backpressure, followed by
// hand-written sequences for round-robin order, source stall, per-beat
// arbitration (LAST_ENABLE=0) and reset in the middle of a packet.
// Define AXIS_RR_ARB_MUX_TID_EN to also check m_axis_tid.
module tb_axis_rr_arb_mux;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int UW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [S*DW-1:0]   s_tdata;
    logic [S-1:0]      s_tvalid;
    logic [S-1:0]      s_tlast;
    logic [S*UW-1:0]   s_tuser;
    logic              m_tready;

    logic [S-1:0]      rdy_a, rdy_b;
    logic [DW-1:0]     md_a, md_b;
    logic              mv_a, mv_b, ml_a, ml_b;
    logic [UW-1:0]     mu_a, mu_b;
`ifdef AXIS_RR_ARB_MUX_TID_EN
    logic [1:0]        tid_a, tid_b;
`endif

    axis_rr_arb_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .LAST_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy_a),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(md_a), .m_axis_tvalid(mv_a), .m_axis_tready(m_tready),
        .m_axis_tlast(ml_a),
`ifdef AXIS_RR_ARB_MUX_TID_EN
        .m_axis_tid(tid_a),
`endif
        .m_axis_tuser(mu_a)
    );

    axis_rr_arb_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .LAST_ENABLE(0)) dut_nl (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy_b),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(md_b), .m_axis_tvalid(mv_b), .m_axis_tready(m_tready),
        .m_axis_tlast(ml_b),
`ifdef AXIS_RR_ARB_MUX_TID_EN
        .m_axis_tid(tid_b),
`endif
        .m_axis_tuser(mu_b)
    );

    // View of whichever instance is under test
    logic          use_nl;
    logic [S-1:0]  rdy;
    logic [DW-1:0] md;
    logic          mv, ml;
    logic [UW-1:0] mu;
    always_comb begin
        rdy = use_nl ? rdy_b : rdy_a;
        md  = use_nl ? md_b  : md_a;
        mv  = use_nl ? mv_b  : mv_a;
        ml  = use_nl ? ml_b  : ml_a;
        mu  = use_nl ? mu_b  : mu_a;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Source model: each port sends pkts_left packets of pkt_len beats.
    // Beat data = port*16 + packet*4 + beat; tuser = data[0].
    int   beats_left [S];
    int   beat_idx   [S];
    int   pkt_idx    [S];
    int   pkts_left  [S];
    int   pkt_len    [S];
    bit   stall      [S];
    int   cycle;
    bit   watch_p0;
    int   viol;

    logic [7:0] out_q  [$];
    bit         last_q [$];
    int         cyc_q  [$];

    task automatic reset_model();
        for (int i = 0; i < S; i++) begin
            beats_left[i] = 0; beat_idx[i] = 0; pkt_idx[i] = 0;
            pkts_left[i] = 0; pkt_len[i] = 0; stall[i] = 1'b0;
        end
        out_q.delete(); last_q.delete(); cyc_q.delete();
    endtask

    task automatic start_port(input int p, input int npkts, input int len);
        pkts_left[p]  = npkts;
        pkt_len[p]    = len;
        beats_left[p] = len;
        beat_idx[p]   = 0;
        pkt_idx[p]    = 0;
    endtask

    task automatic drive_sources();
        for (int i = 0; i < S; i++) begin
            logic [7:0] d;
            d = 8'(i*16 + pkt_idx[i]*4 + beat_idx[i]);
            s_tvalid[i]          = (beats_left[i] > 0) && !stall[i];
            s_tlast[i]           = (beats_left[i] == 1);
            s_tdata[i*DW +: DW]  = d;
            s_tuser[i]           = d[0];
        end
    endtask

    function automatic bit busy();
        bit b;
        b = mv;
        for (int i = 0; i < S; i++) if (beats_left[i] > 0) b = 1'b1;
        return b;
    endfunction

    // One clock cycle: drive at negedge, sample handshakes, advance the model
    task automatic step();
        logic [S-1:0] hs;
        logic         ohs;
        logic [7:0]   od;
        logic         ol;
        drive_sources();
        #1;
        hs  = s_tvalid & rdy;
        ohs = mv && m_tready;
        od  = md;
        ol  = ml;
        if (watch_p0 && rdy[0] && beats_left[3] > 0) viol++;
        @(posedge clk);
        @(negedge clk);
        cycle++;
        if (ohs) begin
            out_q.push_back(od); last_q.push_back(ol); cyc_q.push_back(cycle);
        end
        for (int i = 0; i < S; i++) begin
            if (hs[i]) begin
                beat_idx[i]++;
                beats_left[i]--;
                if (beats_left[i] == 0) begin
                    pkts_left[i]--;
                    pkt_idx[i]++;
                    beat_idx[i] = 0;
                    if (pkts_left[i] > 0) beats_left[i] = pkt_len[i];
                end
            end
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        reset_model();
        m_tready = 1'b1;
        drive_sources();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input string name);
        for (int n = 0; n < 300 && busy(); n++) step();
        check(name, {31'd0, busy()}, 32'd0);
    endtask

    typedef struct {
        logic [3:0] tv;
        logic [3:0] tl;
        logic [7:0] d;
        logic       mr;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [3:0] er;
        logic [1:0] et;
    } vec_t;

    function automatic vec_t mk(logic [3:0] tv, logic [3:0] tl, logic [7:0] d, logic mr,
                                logic ev, logic [7:0] ed, logic el, logic [3:0] er, logic [1:0] et);
        vec_t v;
        v.tv = tv; v.tl = tl; v.d = d; v.mr = mr;
        v.ev = ev; v.ed = ed; v.el = el; v.er = er; v.et = et;
        return v;
    endfunction

    vec_t vecs [17];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Port 2 sends A1,A2,A3; then port 1 sends B1,B2,B3 under 5 cycles of backpressure
        vecs[0]  = mk(4'b0100, 4'b0000, 8'hA1, 1, 0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[1]  = mk(4'b0100, 4'b0000, 8'hA1, 1, 0, 8'h00, 0, 4'b0100, 2'd0);
        vecs[2]  = mk(4'b0100, 4'b0000, 8'hA2, 1, 1, 8'hA1, 0, 4'b0100, 2'd2);
        vecs[3]  = mk(4'b0100, 4'b0100, 8'hA3, 1, 1, 8'hA2, 0, 4'b0100, 2'd2);
        vecs[4]  = mk(4'b0000, 4'b0000, 8'h00, 1, 1, 8'hA3, 1, 4'b0000, 2'd2);
        vecs[5]  = mk(4'b0000, 4'b0000, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[6]  = mk(4'b0010, 4'b0000, 8'hB1, 1, 0, 8'h00, 0, 4'b0000, 2'd0);
        vecs[7]  = mk(4'b0010, 4'b0000, 8'hB1, 1, 0, 8'h00, 0, 4'b0010, 2'd0);
        vecs[8]  = mk(4'b0010, 4'b0000, 8'hB2, 0, 1, 8'hB1, 0, 4'b0000, 2'd1);
        vecs[9]  = mk(4'b0010, 4'b0000, 8'hB2, 0, 1, 8'hB1, 0, 4'b0000, 2'd1);
        vecs[10] = mk(4'b0010, 4'b0000, 8'hB2, 0, 1, 8'hB1, 0, 4'b0000, 2'd1);
        vecs[11] = mk(4'b0010, 4'b0000, 8'hB2, 0, 1, 8'hB1, 0, 4'b0000, 2'd1);
        vecs[12] = mk(4'b0010, 4'b0000, 8'hB2, 0, 1, 8'hB1, 0, 4'b0000, 2'd1);
        vecs[13] = mk(4'b0010, 4'b0000, 8'hB2, 1, 1, 8'hB1, 0, 4'b0010, 2'd1);
        vecs[14] = mk(4'b0010, 4'b0010, 8'hB3, 1, 1, 8'hB2, 0, 4'b0010, 2'd1);
        vecs[15] = mk(4'b0000, 4'b0000, 8'h00, 1, 1, 8'hB3, 1, 4'b0000, 2'd1);
        vecs[16] = mk(4'b0000, 4'b0000, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 2'd0);

        use_nl   = 1'b0;
        watch_p0 = 1'b0;
        viol     = 0;
        cycle    = 0;
        rst      = 1'b1;
        m_tready = 1'b1;
        reset_model();
        drive_sources();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_m_tvalid", {31'd0, mv}, 32'd0);
        check("reset_m_tdata", {24'd0, md}, 32'd0);
        check("reset_m_tlast", {31'd0, ml}, 32'd0);
        check("reset_m_tuser", {31'd0, mu}, 32'd0);
        check("reset_s_tready", {28'd0, rdy}, 32'd0);
`ifdef AXIS_RR_ARB_MUX_TID_EN
        check("reset_m_tid", {30'd0, tid_a}, 32'd0);
`endif

        // Table: one row per cycle, inputs applied before the edge
        for (int r = 0; r < 17; r++) begin
            s_tvalid = vecs[r].tv;
            s_tlast  = vecs[r].tl;
            s_tdata  = {4{vecs[r].d}};
            s_tuser  = {4{vecs[r].d[0]}};
            m_tready = vecs[r].mr;
            #1;
            check($sformatf("vec%0d_s_tready", r), {28'd0, rdy}, {28'd0, vecs[r].er});
            check($sformatf("vec%0d_m_tvalid", r), {31'd0, mv}, {31'd0, vecs[r].ev});
            if (vecs[r].ev) begin
                check($sformatf("vec%0d_m_tdata", r), {24'd0, md}, {24'd0, vecs[r].ed});
                check($sformatf("vec%0d_m_tlast", r), {31'd0, ml}, {31'd0, vecs[r].el});
                check($sformatf("vec%0d_m_tuser", r), {31'd0, mu}, {31'd0, vecs[r].ed[0]});
`ifdef AXIS_RR_ARB_MUX_TID_EN
                check($sformatf("vec%0d_m_tid", r), {30'd0, tid_a}, {30'd0, vecs[r].et});
`endif
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Round robin: all four ports, two 2-beat packets each
        rst_pulse();
        for (int i = 0; i < S; i++) start_port(i, 2, 2);
        run_until_idle("rr_timeout");
        check("rr_beat_count", out_q.size(), 32'd16);
        for (int k = 0; k < 16 && k < out_q.size(); k++) begin
            int ps, p, n, b;
            ps = k / 2; p = ps % 4; n = ps / 4; b = k % 2;
            check($sformatf("rr_data%0d", k), {24'd0, out_q[k]}, 32'(p*16 + n*4 + b));
            check($sformatf("rr_last%0d", k), {31'd0, last_q[k]}, 32'(b == 1));
            if (k > 0)
                check($sformatf("rr_gap%0d", k), 32'(cyc_q[k] - cyc_q[k-1]), (b == 0) ? 32'd2 : 32'd1);
        end

        // Source stall: port 3 holds the grant through a 4-cycle stall
        out_q.delete(); last_q.delete(); cyc_q.delete();
        start_port(3, 1, 4);
        for (int n = 0; n < 50 && beats_left[3] != 3; n++) step();
        check("stall_first_beat", 32'(beats_left[3]), 32'd3);
        stall[3] = 1'b1;
        start_port(0, 1, 2);
        watch_p0 = 1'b1;
        viol = 0;
        repeat (4) step();
        stall[3] = 1'b0;
        for (int n = 0; n < 50 && beats_left[3] != 0; n++) step();
        check("stall_p3_done", 32'(beats_left[3]), 32'd0);
        run_until_idle("stall_timeout");
        watch_p0 = 1'b0;
        check("stall_p0_ready_early", 32'(viol), 32'd0);
        check("stall_beat_count", out_q.size(), 32'd6);
        if (out_q.size() == 6) begin
            check("stall_out0", {24'd0, out_q[0]}, 32'h30);
            check("stall_out1", {24'd0, out_q[1]}, 32'h31);
            check("stall_out2", {24'd0, out_q[2]}, 32'h32);
            check("stall_out3", {24'd0, out_q[3]}, 32'h33);
            check("stall_out4", {24'd0, out_q[4]}, 32'h00);
            check("stall_out5", {24'd0, out_q[5]}, 32'h01);
        end

        // LAST_ENABLE=0: per-beat arbitration between ports 0 and 1
        use_nl = 1'b1;
        rst_pulse();
        start_port(0, 1, 3);
        start_port(1, 1, 3);
        run_until_idle("nl_timeout");
        check("nl_beat_count", out_q.size(), 32'd6);
        for (int k = 0; k < 6 && k < out_q.size(); k++) begin
            check($sformatf("nl_data%0d", k), {24'd0, out_q[k]}, 32'((k % 2) * 16 + k / 2));
            check($sformatf("nl_last%0d", k), {31'd0, last_q[k]}, 32'd1);
        end
        use_nl = 1'b0;

        // Reset in the middle of a port-1 packet
        rst_pulse();
        start_port(1, 1, 4);
        for (int n = 0; n < 50 && !mv; n++) step();
        check("rstmid_started", {31'd0, mv}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rstmid_m_tvalid", {31'd0, mv}, 32'd0);
        check("rstmid_s_tready", {28'd0, rdy}, 32'd0);
        reset_model();
        start_port(0, 1, 2);
        start_port(1, 1, 2);
        run_until_idle("rstmid_timeout");
        check("rstmid_beat_count", out_q.size(), 32'd4);
        if (out_q.size() == 4) begin
            check("rstmid_out0", {24'd0, out_q[0]}, 32'h00);
            check("rstmid_out1", {24'd0, out_q[1]}, 32'h01);
            check("rstmid_out2", {24'd0, out_q[2]}, 32'h10);
            check("rstmid_out3", {24'd0, out_q[3]}, 32'h11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
